// File: rtl/board_redraw_sequencer.sv
// board_redraw_sequencer
// Walks the board colour RAM in raster order and issues one draw command per
// cell to the downstream cell drawer, waiting for the drawer's busy window to
// open and close before moving to the next cell.
//
// Ports:
//   clock, resetn      system clock (rising edge), synchronous active-low reset
//   start              pulse, requests a full-board redraw (ignored unless idle)
//   rd_addr / rd_data  board RAM address (row*COLS+col) / colour, 1-cycle read
//   draw_x, draw_y     top-left pixel of the current cell
//   draw_colour        colour of the current cell
//   draw_go            one-cycle launch pulse to the drawer
//   draw_busy          drawer plot window
//   busy               high from accepted start until done
//   done               one-cycle pulse after the last cell
//   timeout_err        sticky, a cell's ack wait expired
module board_redraw_sequencer #(
   parameter int unsigned COLS        = 10,
   parameter int unsigned ROWS        = 12,
   parameter int unsigned CELL        = 10,
   parameter int unsigned X0          = 0,
   parameter int unsigned Y0          = 0,
   parameter int unsigned ACK_TIMEOUT = 7
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       start,
   output logic [6:0] rd_addr,
   input  logic [2:0] rd_data,
   output logic [6:0] draw_x,
   output logic [6:0] draw_y,
   output logic [2:0] draw_colour,
   output logic       draw_go,
   input  logic       draw_busy,
   output logic       busy,
   output logic       done,
   output logic       timeout_err
);

   localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [6:0]       X0_V     = 7'(X0);
   localparam logic [6:0]       Y0_V     = 7'(Y0);
   localparam logic [6:0]       CELL_V   = 7'(CELL);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      LATCH,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE,
      NEXT,
      DONE
   } state_t;

   state_t           state, state_next;
   logic [COL_W-1:0] col, col_next;
   logic [ROW_W-1:0] row, row_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [6:0]       xacc, xacc_next;
   logic [6:0]       yacc, yacc_next;
   logic [6:0]       addr_next;
   logic [6:0]       draw_x_next, draw_y_next;
   logic [2:0]       colour_next;
   logic             go_next, busy_next, done_next, terr_next;

   // State and registered outputs
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state       <= IDLE;
         col         <= '0;
         row         <= '0;
         cnt         <= '0;
         xacc        <= X0_V;
         yacc        <= Y0_V;
         rd_addr     <= '0;
         draw_x      <= X0_V;
         draw_y      <= Y0_V;
         draw_colour <= '0;
         draw_go     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_next;
         col         <= col_next;
         row         <= row_next;
         cnt         <= cnt_next;
         xacc        <= xacc_next;
         yacc        <= yacc_next;
         rd_addr     <= addr_next;
         draw_x      <= draw_x_next;
         draw_y      <= draw_y_next;
         draw_colour <= colour_next;
         draw_go     <= go_next;
         busy        <= busy_next;
         done        <= done_next;
         timeout_err <= terr_next;
      end
   end

   // Next state and next register values; outputs are decided one cycle
   // early so draw_go/done are high exactly in ISSUE/DONE.
   always_comb begin
      state_next  = state;
      col_next    = col;
      row_next    = row;
      cnt_next    = cnt;
      xacc_next   = xacc;
      yacc_next   = yacc;
      addr_next   = rd_addr;
      draw_x_next = draw_x;
      draw_y_next = draw_y;
      colour_next = draw_colour;
      go_next     = 1'b0;
      busy_next   = busy;
      done_next   = 1'b0;
      terr_next   = timeout_err;

      case (state)
         IDLE: begin
            if (start) begin
               state_next = READ;
               col_next   = '0;
               row_next   = '0;
               addr_next  = '0;
               xacc_next  = X0_V;
               yacc_next  = Y0_V;
               busy_next  = 1'b1;
            end
         end
         READ: state_next = LATCH;
         LATCH: begin
            colour_next = rd_data;
            draw_x_next = xacc;
            draw_y_next = yacc;
            go_next     = 1'b1;
            state_next  = ISSUE;
         end
         ISSUE: begin
            cnt_next   = '0;
            state_next = WAIT_ACK;
         end
         WAIT_ACK: begin
            // A drawer already busy here is taken as the ack.
            if (draw_busy) begin
               state_next = WAIT_DONE;
            end else begin
               cnt_next = cnt + CNT_W'(1);
               if (cnt == CNT_LAST) begin
                  terr_next  = 1'b1;
                  state_next = NEXT;
               end
            end
         end
         WAIT_DONE: begin
            if (!draw_busy) state_next = NEXT;
         end
         NEXT: begin
            addr_next = rd_addr + 7'd1;
            if (col == COL_LAST) begin
               col_next  = '0;
               xacc_next = X0_V;
               yacc_next = yacc + CELL_V;
               row_next  = row + ROW_W'(1);
            end else begin
               col_next  = col + COL_W'(1);
               xacc_next = xacc + CELL_V;
            end
            if (col == COL_LAST && row == ROW_LAST) begin
               state_next = DONE;
               done_next  = 1'b1;
               busy_next  = 1'b0;
            end else begin
               state_next = READ;
            end
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_board_redraw_sequencer.sv
// Directed bench for board_redraw_sequencer: behavioural RAM and drawer,
// scoreboard of expected draw commands pushed at start, popped on draw_go.
module tb_board_redraw_sequencer;

   logic       clock = 1'b0;
   logic       resetn;
   logic       start;
   logic [6:0] rd_addr;
   logic [2:0] rd_data;
   logic [6:0] draw_x, draw_y;
   logic [2:0] draw_colour;
   logic       draw_go;
   logic       draw_busy;
   logic       busy, done, timeout_err;

   board_redraw_sequencer dut (
      .clock       (clock),
      .resetn      (resetn),
      .start       (start),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .draw_x      (draw_x),
      .draw_y      (draw_y),
      .draw_colour (draw_colour),
      .draw_go     (draw_go),
      .draw_busy   (draw_busy),
      .busy        (busy),
      .done        (done),
      .timeout_err (timeout_err)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [6:0] x;
      logic [6:0] y;
      logic [2:0] c;
      logic [6:0] a;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   go_cnt = 0;
   int   done_cnt = 0;
   int   last_go = 0;
   int   go_gap = 0;
   int   busy_len = 2;

   // RAM: RAM[a] = a % 8, one-cycle synchronous read
   always @(posedge clock) rd_data <= rd_addr[2:0];

   // Drawer: busy rises 2 cycles after go, stays high busy_len cycles (0 = never)
   logic pend;
   int   bcnt;
   always @(posedge clock) begin
      if (!resetn) begin
         draw_busy <= 1'b0;
         pend      <= 1'b0;
         bcnt      <= 0;
      end else begin
         pend <= draw_go && (busy_len != 0);
         if (pend) begin
            draw_busy <= 1'b1;
            bcnt      <= busy_len - 1;
         end else if (draw_busy) begin
            if (bcnt == 0) draw_busy <= 1'b0;
            else bcnt <= bcnt - 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // One cycle; samples outputs at the falling edge and scores draw_go pulses
   task automatic tick();
      exp_t e;
      @(negedge clock);
      cyc++;
      if (draw_go) begin
         go_cnt++;
         go_gap  = cyc - last_go;
         last_go = cyc;
         check("go_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("go_x", 32'(draw_x), 32'(e.x));
            check("go_y", 32'(draw_y), 32'(e.y));
            check("go_colour", 32'(draw_colour), 32'(e.c));
            check("go_addr", 32'(rd_addr), 32'(e.a));
         end
      end
      if (done) done_cnt++;
   endtask

   task automatic launch();
      for (int k = 0; k < 120; k++)
         sb.push_back('{x: 7'((k % 10) * 10), y: 7'((k / 10) * 10), c: 3'(k % 8), a: 7'(k)});
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic wait_done(input int limit);
      int i;
      for (i = 0; i < limit && !done; i++) tick();
      check("done_seen", 32'(done), 32'd1);
   endtask

   initial begin
      resetn = 1'b0;
      start  = 1'b0;
      repeat (3) tick();
      check("rst_rd_addr", 32'(rd_addr), 32'd0);
      check("rst_draw_x", 32'(draw_x), 32'd0);
      check("rst_draw_y", 32'(draw_y), 32'd0);
      check("rst_colour", 32'(draw_colour), 32'd0);
      resetn = 1'b1;

      // Idle for 20 cycles
      repeat (20) tick();
      check("idle_go_cnt", 32'(go_cnt), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done_cnt), 32'd0);
      check("idle_terr", 32'(timeout_err), 32'd0);
      check("idle_rd_addr", 32'(rd_addr), 32'd0);

      // Full frame, long drawer busy
      busy_len = 300; go_cnt = 0; done_cnt = 0;
      launch();
      wait_done(40000);
      check("frame_busy_in_done", 32'(busy), 32'd0);
      tick();
      check("frame_go_cnt", 32'(go_cnt), 32'd120);
      check("frame_sb_empty", 32'(sb.size()), 32'd0);
      check("frame_done_cnt", 32'(done_cnt), 32'd1);
      check("frame_busy_after", 32'(busy), 32'd0);
      check("frame_terr", 32'(timeout_err), 32'd0);

      // Wrap check, 3-cycle busy (scoreboard covers pulses 9, 10, 119)
      busy_len = 3; go_cnt = 0; done_cnt = 0;
      launch();
      wait_done(5000);
      tick();
      check("wrap_go_cnt", 32'(go_cnt), 32'd120);
      check("wrap_sb_empty", 32'(sb.size()), 32'd0);
      check("wrap_done_cnt", 32'(done_cnt), 32'd1);

      // start during WAIT_DONE of cell 5 and in the DONE cycle is ignored
      busy_len = 2; go_cnt = 0; done_cnt = 0;
      launch();
      for (int i = 0; i < 200 && !(go_cnt == 6 && draw_busy); i++) tick();
      check("c5_reached", 32'(go_cnt == 6 && draw_busy), 32'd1);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(5000);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ign_busy_idle", 32'(busy), 32'd0);
      check("ign_done_cnt", 32'(done_cnt), 32'd1);
      check("ign_go_cnt", 32'(go_cnt), 32'd120);
      check("ign_sb_empty", 32'(sb.size()), 32'd0);
      launch();
      wait_done(5000);
      tick();
      check("relaunch_go_cnt", 32'(go_cnt), 32'd240);
      check("relaunch_done_cnt", 32'(done_cnt), 32'd2);
      check("relaunch_sb_empty", 32'(sb.size()), 32'd0);

      // Reset during WAIT_DONE of cell 40
      busy_len = 2; go_cnt = 0; done_cnt = 0;
      launch();
      for (int i = 0; i < 2000 && !(go_cnt == 41 && draw_busy); i++) tick();
      check("c40_reached", 32'(go_cnt == 41 && draw_busy), 32'd1);
      tick();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_go", 32'(draw_go), 32'd0);
      check("mid_rst_addr", 32'(rd_addr), 32'd0);
      sb.delete();
      go_cnt = 0;
      repeat (20) tick();
      check("mid_rst_no_go", 32'(go_cnt), 32'd0);
      busy_len = 1; done_cnt = 0;
      launch();
      wait_done(5000);
      tick();
      check("restart_go_cnt", 32'(go_cnt), 32'd120);
      check("restart_sb_empty", 32'(sb.size()), 32'd0);

      // Drawer never acks: 7-cycle wait per cell, sticky timeout_err
      busy_len = 0; go_cnt = 0; done_cnt = 0;
      launch();
      wait_done(5000);
      check("to_terr_at_done", 32'(timeout_err), 32'd1);
      check("to_go_gap", 32'(go_gap), 32'd11);
      repeat (10) tick();
      check("to_go_cnt", 32'(go_cnt), 32'd120);
      check("to_sb_empty", 32'(sb.size()), 32'd0);
      check("to_terr_sticky", 32'(timeout_err), 32'd1);
      check("to_busy_after", 32'(busy), 32'd0);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      check("to_terr_cleared", 32'(timeout_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/board_redraw_sequencer.md
Name: board_redraw_sequencer

Overview:
- Walks the Tetris board colour memory cell by cell and issues one draw command per cell to the downstream cell-drawer FSM.
- Per cell it provides the drawer's top-left x/y, colour and a one-cycle go pulse, then waits for the drawer's plot/busy window to open and close before moving on.
- Sits between the game-logic board RAM and the cell drawer that feeds the VGA adapter.

Parameters:
- COLS, 10, board width in cells.
- ROWS, 12, board height in cells.
- CELL, 10, pixel pitch of one cell in x and y.
- X0, 0, pixel x of cell (0,0).
- Y0, 0, pixel y of cell (0,0).
- ACK_TIMEOUT, 7, maximum cycles to wait for draw_busy to rise after draw_go.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  pulse; requests a full-board redraw.
- rd_addr  out  7  board RAM address, row*COLS+col.
- rd_data  in  3  cell colour; synchronous read, valid 1 cycle after rd_addr.
- draw_x  out  7  top-left pixel x to drawer.
- draw_y  out  7  top-left pixel y to drawer.
- draw_colour  out  3  colour to drawer.
- draw_go  out  1  one-cycle launch pulse to drawer.
- draw_busy  in  1  drawer plot signal; high while the drawer writes pixels.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last cell completes.
- timeout_err  out  1  sticky; set if any cell's ACK wait expired.

Behaviour:
- Reset (resetn=0 at posedge): state IDLE; col=row=0; rd_addr=0; draw_x=X0, draw_y=Y0, draw_colour=0; draw_go=0, busy=0, done=0, timeout_err=0. Reset mid-frame aborts immediately with no further draw_go. Only reset clears timeout_err.
- States: IDLE, READ, LATCH, ISSUE, WAIT_ACK, WAIT_DONE, NEXT, DONE.
- IDLE:
  - start=1 -> READ; clear col, row, address, xacc=X0, yacc=Y0; busy=1 from the next cycle.
  - start is ignored in every non-IDLE state, including DONE.
- READ: rd_addr holds the current address -> LATCH.
- LATCH: register draw_colour<=rd_data, draw_x<=xacc, draw_y<=yacc -> ISSUE.
- ISSUE:
  - draw_go=1 for exactly this cycle; clear the timeout counter -> WAIT_ACK.
  - draw_x, draw_y and draw_colour stay stable from LATCH until the next LATCH.
- WAIT_ACK:
  - draw_busy=1 -> WAIT_DONE.
  - Otherwise increment the counter; when it reaches ACK_TIMEOUT, set timeout_err and go to NEXT. The cell counts as done.
  - A drawer that loads then plots gives draw_busy high 2 cycles after draw_go.
- WAIT_DONE: draw_busy=0 -> NEXT. No timeout here.
- NEXT:
  - If col==COLS-1: col=0, xacc=X0, yacc+=CELL, row+=1. Otherwise col+=1, xacc+=CELL.
  - Address increments by 1.
  - If the cell just finished was (COLS-1, ROWS-1) -> DONE, else READ.
- DONE: done=1 for one cycle, busy=0 in the same cycle -> IDLE.
- Arithmetic:
  - Coordinates come from accumulators, no multiplier. All 7-bit unsigned.
  - Defaults give max x=90 and max y=110, which fit 7 bits. Parameter choices that overflow are illegal and need no check.
- Latency per cell: 5 cycles of overhead (READ, LATCH, ISSUE, ACK detect, NEXT) plus the drawer busy time.
- Exactly COLS*ROWS draw_go pulses per frame, in raster order (row-major, col fastest).
- draw_busy already high on entering WAIT_ACK (drawer stuck): accepted as the ACK.

Test Plan:
- Reset then idle: no start for 20 cycles -> draw_go, busy, done and timeout_err all 0; rd_addr=0.
- Full frame with a behavioural drawer (busy high 2 cycles after go, for 300 cycles); RAM[a]=a%8:
  - exactly 120 draw_go pulses.
  - pulse k carries x=(k%10)*10, y=(k/10)*10, colour=k%8.
  - one done pulse; busy low afterwards; timeout_err=0.
- Wrap check with a 3-cycle busy: pulse 9 -> (90,0); pulse 10 -> (0,10); last pulse 119 -> (90,110), address 119.
- Drawer never asserts busy:
  - each cell waits 7 cycles, then advances.
  - 120 go pulses; timeout_err=1 and stays 1 after done until resetn=0.
- start asserted again during WAIT_DONE of cell 5 and in the DONE cycle -> both ignored; frame count 1; a start one cycle after done launches a new frame.
- resetn=0 during WAIT_DONE of cell 40 -> next cycle IDLE; busy=0; no further draw_go; a subsequent start restarts at address 0, (0,0).
